tdm_mux: RTL and testbench

- Time-division multiplexing transmitter. Snapshots N_CH parallel channel bits and sends them one per slot on a single serial line D.
- Drives the matching slot index SEL, so a downstream 1-to-N_CH demultiplexer driven by {D,SEL} rebuilds the word one channel per slot.
- Sits between parallel status/data sources and the shared TDM link.

---
 rtl/tdm_if.sv | 19 +
 rtl/tdm_mux.sv | 86 ++++++++
 tb/tb_tdm_mux.sv | 128 ++++++++++++
 3 files changed

// File: rtl/tdm_if.sv
// TDM transmitter bus: frame control and parallel channel bits in, serial slot out.
// The transmitter takes the slave modport.
interface tdm_if #(
  parameter int N_CH  = 8,
  parameter int SEL_W = $clog2(N_CH)
);
  logic             EN;
  logic             START;
  logic [N_CH-1:0]  X;
  logic             D;
  logic [SEL_W-1:0] SEL;
  logic             VALID;
  logic             FRAME;
  logic             BUSY;
  logic             DONE;

  modport master (output EN, START, X, input D, SEL, VALID, FRAME, BUSY, DONE);
  modport slave  (input EN, START, X, output D, SEL, VALID, FRAME, BUSY, DONE);
endinterface

// File: rtl/tdm_mux.sv
// TDM transmitter: snapshots N_CH channel bits at launch and sends one per slot on D/SEL.
// Define TDM_MSB_FIRST_EN to transmit slots N_CH-1 down to 0 instead of 0 up to N_CH-1.
module tdm_mux #(
  parameter int N_CH  = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input logic   CLK,
  input logic   N_RESET,
  tdm_if.slave  bus
);

`ifdef TDM_MSB_FIRST_EN
  localparam logic [SEL_W-1:0] FIRST = SEL_W'(N_CH - 1);
  localparam logic [SEL_W-1:0] LAST  = '0;
`else
  localparam logic [SEL_W-1:0] FIRST = '0;
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(N_CH - 1);
`endif

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state, state_n;
  logic [N_CH-1:0]  snap, snap_n;
  logic [SEL_W-1:0] sel, sel_n;
  logic             done, done_n;

  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      state <= IDLE;
      snap  <= '0;
      sel   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      snap  <= snap_n;
      sel   <= sel_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    snap_n  = snap;
    sel_n   = sel;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.START) begin
          state_n = SEND;
          snap_n  = bus.X;
          sel_n   = FIRST;
        end
      end
      SEND: begin
        if (bus.EN) begin
          if (sel == LAST) begin
            done_n = 1'b1;
            // START on the closing edge chains the next frame with no idle slot
            if (bus.START) begin
              snap_n = bus.X;
              sel_n  = FIRST;
            end else begin
              state_n = IDLE;
            end
          end else begin
`ifdef TDM_MSB_FIRST_EN
            sel_n = sel - 1'b1;
`else
            sel_n = sel + 1'b1;
`endif
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs decode straight from state so an async reset clears them at once
  assign bus.D     = (state == SEND) & snap[sel];
  assign bus.SEL   = sel;
  assign bus.VALID = (state == SEND);
  assign bus.BUSY  = (state == SEND);
  assign bus.FRAME = (state == SEND) && (sel == FIRST);
  assign bus.DONE  = done;

endmodule

// File: tb/tb_tdm_mux.sv
// Bench for tdm_mux: directed frames plus random EN/START/X against a slot-count model.
module tb_tdm_mux;
  localparam int N_CH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tdm_if #(.N_CH(N_CH)) bus ();
  tdm_mux #(.N_CH(N_CH)) dut (.CLK(clk), .N_RESET(rst_n), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: frame in progress, slot number within frame, captured word
  bit            m_busy;
  int            m_k;
  logic [N_CH-1:0] m_snap;
  int            m_lastsel;
  bit            m_done;

  function automatic int slot_idx(input int k);
`ifdef TDM_MSB_FIRST_EN
    return N_CH - 1 - k;
`else
    return k;
`endif
  endfunction

  task automatic model_reset();
    m_busy = 0; m_k = 0; m_snap = '0; m_lastsel = 0; m_done = 0;
  endtask

  task automatic model_edge(input bit en, input bit start, input logic [N_CH-1:0] x);
    m_done = 0;
    if (!m_busy) begin
      if (start) begin m_busy = 1; m_k = 0; m_snap = x; end
    end else if (en) begin
      if (m_k == N_CH - 1) begin
        m_done = 1;
        if (start) begin m_k = 0; m_snap = x; end
        else begin m_busy = 0; m_lastsel = slot_idx(N_CH - 1); end
      end else begin
        m_k++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic check_all(input string tag);
    int es;
    es = m_busy ? slot_idx(m_k) : m_lastsel;
    chk({tag, " SEL"},   32'(bus.SEL),   32'(es));
    chk({tag, " D"},     32'(bus.D),     32'(m_busy ? m_snap[es] : 1'b0));
    chk({tag, " VALID"}, 32'(bus.VALID), 32'(m_busy));
    chk({tag, " BUSY"},  32'(bus.BUSY),  32'(m_busy));
    chk({tag, " FRAME"}, 32'(bus.FRAME), 32'(m_busy && m_k == 0));
    chk({tag, " DONE"},  32'(bus.DONE),  32'(m_done));
  endtask

  task automatic step(input string tag, input bit en, input bit start, input logic [N_CH-1:0] x);
    bus.EN = en; bus.START = start; bus.X = x;
    @(posedge clk);
    if (rst_n) model_edge(en, start, x);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    bit d_seq_ok;
    logic [N_CH-1:0] seen;
    bus.EN = 1'b0; bus.START = 1'b0; bus.X = '0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step("idle", 1'b0, 1'b0, N_CH'($urandom));

    // Plain frame, collecting D by SEL to compare with the launched word
    step("launch", 1'b1, 1'b1, 8'b1010_0110);
    seen = '0;
    for (int i = 0; i < N_CH; i++) begin
      seen[bus.SEL] = bus.D;
      step("frame", 1'b1, 1'b0, 8'hFF);
    end
    chk("frame word", 32'(seen), 32'h0000_00A6);
    step("after", 1'b1, 1'b0, '0);

    // Stall 3 cycles at SEL index for slot 3, X changed mid-frame
    step("launch2", 1'b1, 1'b1, 8'b1010_0110);
    for (int i = 0; i < 3; i++) step("adv2", 1'b1, 1'b0, 8'hFF);
    for (int i = 0; i < 3; i++) step("stall", 1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 5; i++) step("adv2b", 1'b1, 1'b0, 8'hFF);
    step("idle2", 1'b1, 1'b0, 8'hFF);

    // Back-to-back: START on the last advancing edge
    step("launch3", 1'b1, 1'b1, 8'b1010_0110);
    for (int i = 0; i < N_CH - 1; i++) step("adv3", 1'b1, 1'b0, '0);
    step("b2b", 1'b1, 1'b1, 8'h81);
    for (int i = 0; i < N_CH; i++) step("frame81", 1'b1, 1'b0, '0);

    // Reset in the middle of a frame
    step("launch4", 1'b1, 1'b1, 8'h5A);
    for (int i = 0; i < 4; i++) step("adv4", 1'b1, 1'b0, '0);
    #1 rst_n = 1'b0;
    model_reset();
    #1 check_all("midrst");
    @(negedge clk);
    check_all("inrst");
    rst_n = 1'b1;
    step("postrst", 1'b1, 1'b0, '0);
    step("relaunch", 1'b1, 1'b1, 8'h3C);
    for (int i = 0; i < N_CH + 1; i++) step("adv5", 1'b1, 1'b0, '0);

    // Random EN/START/X traffic
    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), N_CH'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
